// File: rtl/common_sync_deglitch.sv
// Glitch filter placed after a level synchronizer: clean level, edge strobes and a saturating event counter.
// Optional IRQ flag (irq_o / irq_clr_i) is built when COMMON_SYNC_DEGLITCH_IRQ_EN is defined.
module common_sync_deglitch #(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EDGE_SEL    = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             data_i,
    input  logic             cnt_clr_i,
`ifdef COMMON_SYNC_DEGLITCH_IRQ_EN
    input  logic             irq_clr_i,
    output logic             irq_o,
`endif
    output logic             data_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    if (FILT_CYCLES == 0 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("common_sync_deglitch: FILT_CYCLES must be in 1..255");
    end
    if (EDGE_SEL > 2) begin : g_bad_edge
        $error("common_sync_deglitch: EDGE_SEL must be 0, 1 or 2");
    end
    if (CNT_W == 0) begin : g_bad_cnt
        $error("common_sync_deglitch: CNT_W must be at least 1");
    end

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    localparam logic [7:0]       FILT_LAST = 8'(FILT_CYCLES - 1);
    localparam logic             CNT_RISE  = (EDGE_SEL == 0) || (EDGE_SEL == 2);
    localparam logic             CNT_FALL  = (EDGE_SEL == 1) || (EDGE_SEL == 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q,    state_d;
    logic [7:0]       filt_cnt_q, filt_cnt_d;
    logic             data_q,     data_d;
    logic             rise_q,     rise_d;
    logic             fall_q,     fall_d;
    logic             busy_q,     busy_d;
    logic [CNT_W-1:0] evt_cnt_q,  evt_cnt_d;
    logic             differs;
    logic             edge_hit;

    assign differs = (data_i != data_q);

    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        filt_cnt_d = filt_cnt_q;
        data_d     = data_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;

        if (!en_i) begin
            state_d    = ST_STABLE;
            filt_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                ST_STABLE: begin
                    if (differs) begin
                        if (FILT_CYCLES == 1) begin
                            data_d = data_i;
                            rise_d = data_i;
                            fall_d = ~data_i;
                        end else begin
                            state_d    = ST_QUALIFY;
                            filt_cnt_d = 8'd1;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (!differs) begin
                        state_d    = ST_STABLE;
                        filt_cnt_d = 8'd0;
                    end else if (filt_cnt_q == FILT_LAST) begin
                        data_d     = data_i;
                        rise_d     = data_i;
                        fall_d     = ~data_i;
                        state_d    = ST_STABLE;
                        filt_cnt_d = 8'd0;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = ST_STABLE;
                    filt_cnt_d = 8'd0;
                end
            endcase
        end

        busy_d = (state_d == ST_QUALIFY);
    end

    // The counter looks at the registered strobes, so a clear arriving alongside a visible strobe still counts it.
    assign edge_hit = (rise_q && CNT_RISE) || (fall_q && CNT_FALL);

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (cnt_clr_i) begin
            evt_cnt_d = edge_hit ? CNT_ONE : '0;
        end else if (edge_hit && (evt_cnt_q != CNT_MAX)) begin
            evt_cnt_d = evt_cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_STABLE;
            filt_cnt_q <= 8'd0;
            data_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            filt_cnt_q <= filt_cnt_d;
            data_q     <= data_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign data_o    = data_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign busy_o    = busy_q;
    assign evt_cnt_o = evt_cnt_q;

`ifdef COMMON_SYNC_DEGLITCH_IRQ_EN
    logic irq_q, irq_d;

    // Set has priority over clear, and saturation of the counter does not mask it.
    always_comb begin
        irq_d = irq_q;
        if (edge_hit) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
